// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR generator and its combinational step.
package lfsr_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } lfsr_fsm_e;

  localparam int LFSR_FIB = 0;
  localparam int LFSR_GAL = 1;

  // Bit-counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR advance; Fibonacci or Galois selected at elaboration.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter int               MODE  = LFSR_FIB
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  generate
    if (MODE == LFSR_GAL) begin : g_galois
      // Outgoing MSB folds the tap mask into the shifted state.
      assign nxt = {cur[WIDTH-2:0], 1'b0} ^ (cur[WIDTH-1] ? TAPS : '0);
    end else begin : g_fibonacci
      assign nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};
    end
  endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// LFSR pseudo-random source with seed load, lock-up protection and a snapshot
// serialiser. Handshake: out is meaningful only in cycles where valid is high.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
  parameter int               MODE         = LFSR_FIB,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = 8'h01,
  parameter bit               MSB_FIRST    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             enable,
  input  logic             out_enable,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             lockup,
  output logic [WIDTH-1:0] state
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  lfsr_fsm_e        fsm_q;
  lfsr_fsm_e        fsm_d;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] snap_q;
  logic [CW-1:0]    cnt_q;
  logic             lockup_q;

  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] safe_step;
  logic             seed_zero;
  logic             step_zero;
  logic             do_snap;
  logic             do_step;
  logic [CW-1:0]    bit_idx;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .MODE  (MODE)
  ) u_step (
    .cur (lfsr_q),
    .nxt (step_val)
  );

  // Zero seeds and zero steps are both replaced by the default seed.
  always_comb begin
    seed_zero = (seed == '0);
    step_zero = (step_val == '0);
    load_val  = seed_zero ? SEED_DEFAULT : seed;
    safe_step = step_zero ? SEED_DEFAULT : step_val;
    do_snap   = (fsm_q == ST_IDLE) && !seed_load && out_enable;
    do_step   = (fsm_q == ST_IDLE) && !seed_load && !out_enable && enable;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE: begin
        if (do_snap) fsm_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (seed_load || (cnt_q == LAST)) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid   = (fsm_q == ST_SHIFT);
    busy    = (fsm_q == ST_SHIFT);
    bit_idx = MSB_FIRST ? (LAST - cnt_q) : cnt_q;
    out     = valid ? snap_q[bit_idx] : 1'b0;
  end

  // The generator state only moves in IDLE, or on a load that aborts a readout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q   <= SEED_DEFAULT;
      snap_q   <= '0;
      cnt_q    <= '0;
      lockup_q <= 1'b0;
    end else begin
      lockup_q <= (seed_load && seed_zero) || (do_step && step_zero);
      if (seed_load) begin
        lfsr_q <= load_val;
      end else if (do_step) begin
        lfsr_q <= safe_step;
      end
      if (do_snap) begin
        snap_q <= lfsr_q;
      end
      if ((fsm_q == ST_SHIFT) && (fsm_d == ST_SHIFT)) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign state  = lfsr_q;
  assign lockup = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: four parameterisations share one stimulus stream and are
// compared each cycle against a transaction-level model of the generator.
module tb_lfsr_gen;
  import lfsr_pkg::*;

  localparam int N = 4;
  localparam int M_MODE [N] = '{0, 1, 1, 0};
  localparam logic [7:0] M_TAPS [N] = '{8'hB8, 8'h1D, 8'h1D, 8'h02};
  localparam bit M_MSB [N] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst;
  logic       seed_load;
  logic [7:0] seed;
  logic       enable;
  logic       out_enable;
  logic       o_out [N];
  logic       o_valid [N];
  logic       o_busy [N];
  logic       o_lockup [N];
  logic [7:0] o_state [N];

  logic [7:0] m_state [N];
  logic       m_lock [N];
  logic       exp_q [N][$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .MODE(LFSR_FIB), .SEED_DEFAULT(8'h01), .MSB_FIRST(1'b0)) u_fib (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .enable(enable),
    .out_enable(out_enable), .out(o_out[0]), .valid(o_valid[0]), .busy(o_busy[0]),
    .lockup(o_lockup[0]), .state(o_state[0]));

  lfsr_gen #(.WIDTH(8), .TAPS(8'h1D), .MODE(LFSR_GAL), .SEED_DEFAULT(8'h01), .MSB_FIRST(1'b0)) u_gal (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .enable(enable),
    .out_enable(out_enable), .out(o_out[1]), .valid(o_valid[1]), .busy(o_busy[1]),
    .lockup(o_lockup[1]), .state(o_state[1]));

  lfsr_gen #(.WIDTH(8), .TAPS(8'h1D), .MODE(LFSR_GAL), .SEED_DEFAULT(8'h01), .MSB_FIRST(1'b1)) u_gal_msb (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .enable(enable),
    .out_enable(out_enable), .out(o_out[2]), .valid(o_valid[2]), .busy(o_busy[2]),
    .lockup(o_lockup[2]), .state(o_state[2]));

  lfsr_gen #(.WIDTH(8), .TAPS(8'h02), .MODE(LFSR_FIB), .SEED_DEFAULT(8'h01), .MSB_FIRST(1'b0)) u_degen (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .enable(enable),
    .out_enable(out_enable), .out(o_out[3]), .valid(o_valid[3]), .busy(o_busy[3]),
    .lockup(o_lockup[3]), .state(o_state[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Next value from the arithmetic definition: doubling modulo 256 plus feedback.
  function automatic logic [7:0] ref_next(input int i, input logic [7:0] s);
    int v;
    int ones;
    logic [7:0] t;
    t = M_TAPS[i];
    if (M_MODE[i] == 1) begin
      v = (int'(s) * 2) % 256;
      if (int'(s) >= 128) v = v ^ int'(t);
    end else begin
      ones = 0;
      for (int k = 0; k < 8; k++) if (s[k] && t[k]) ones++;
      v = (int'(s) * 2) % 256 + (ones % 2);
    end
    return v[7:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 8'h01;
      m_lock[i]  = 1'b0;
      exp_q[i].delete();
    end
  endtask

  task automatic model_load(input int i, input logic [7:0] sd);
    if (sd == 8'h00) begin
      m_state[i] = 8'h01;
      m_lock[i]  = 1'b1;
    end else begin
      m_state[i] = sd;
    end
  endtask

  // Effect of one rising edge given the inputs currently driven.
  task automatic model_edge();
    logic [7:0] n;
    for (int i = 0; i < N; i++) begin
      m_lock[i] = 1'b0;
      if (exp_q[i].size() != 0) begin
        if (seed_load) begin
          model_load(i, seed);
          exp_q[i].delete();
        end else begin
          void'(exp_q[i].pop_front());
        end
      end else if (seed_load) begin
        model_load(i, seed);
      end else if (out_enable) begin
        for (int k = 0; k < 8; k++)
          exp_q[i].push_back(M_MSB[i] ? m_state[i][7-k] : m_state[i][k]);
      end else if (enable) begin
        n = ref_next(i, m_state[i]);
        if (n == 8'h00) begin
          n = 8'h01;
          m_lock[i] = 1'b1;
        end
        m_state[i] = n;
      end
    end
  endtask

  task automatic check_all();
    logic act;
    for (int i = 0; i < N; i++) begin
      act = (exp_q[i].size() != 0);
      chk($sformatf("d%0d_valid", i), 32'(o_valid[i]), 32'(act));
      chk($sformatf("d%0d_busy", i), 32'(o_busy[i]), 32'(act));
      chk($sformatf("d%0d_out", i), 32'(o_out[i]), act ? 32'(exp_q[i][0]) : 32'd0);
      chk($sformatf("d%0d_state", i), 32'(o_state[i]), 32'(m_state[i]));
      chk($sformatf("d%0d_lockup", i), 32'(o_lockup[i]), 32'(m_lock[i]));
    end
  endtask

  task automatic cyc(input logic sl, input logic [7:0] sd, input logic en, input logic oe);
    seed_load  = sl;
    seed       = sd;
    enable     = en;
    out_enable = oe;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [7:0] bits0;
    logic [7:0] bits1;
    logic [7:0] bits2;
    logic [7:0] saved;
    logic [7:0] fib_exp [4];
    int nvalid;
    int seen_zero;

    rst = 1'b1; seed_load = 1'b0; seed = 8'h00; enable = 1'b0; out_enable = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    check_all();

    // Fibonacci stepping and LSB-first readout.
    fib_exp = '{8'h02, 8'h04, 8'h08, 8'h11};
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk($sformatf("fib_step%0d", k), 32'(o_state[0]), 32'(fib_exp[k]));
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    nvalid = 0;
    for (int k = 0; k < 8; k++) begin
      bits0[k] = o_out[0];
      nvalid += int'(o_valid[0]);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("fib_bits", 32'(bits0), 32'h11);
    chk("fib_nvalid", nvalid, 8);
    chk("fib_busy_end", 32'(o_busy[0]), 0);

    // Maximal period of the default taps.
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    seen_zero = 0;
    for (int k = 1; k <= 255; k++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      if (o_state[0] == 8'h00) seen_zero++;
      if (k == 254) chk("period_254_not_seed", 32'(o_state[0] == 8'h01), 0);
    end
    chk("period_255", 32'(o_state[0]), 32'h01);
    chk("period_no_zero", seen_zero, 0);

    // Galois step and both serial orders; the degenerate taps lock up here.
    cyc(1'b1, 8'h80, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("gal_step", 32'(o_state[1]), 32'h1D);
    chk("degen_state", 32'(o_state[3]), 32'h01);
    chk("degen_lockup", 32'(o_lockup[3]), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      bits1[k] = o_out[1];
      bits2[k] = o_out[2];
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("gal_lsb_bits", 32'(bits1), 32'h1D);
    chk("gal_msb_bits", 32'(bits2), 32'hB8);

    // Zero seed substitution and a clean nonzero load.
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    chk("zero_seed_state", 32'(o_state[0]), 32'h01);
    chk("zero_seed_lockup", 32'(o_lockup[0]), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("zero_seed_pulse_end", 32'(o_lockup[0]), 0);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("nonzero_no_lockup", 32'(o_lockup[0]), 0);

    // Abort on the third bit.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    nvalid = int'(o_valid[0]);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    nvalid += int'(o_valid[0]);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    nvalid += int'(o_valid[0]);
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("abort_bits", nvalid, 3);
    chk("abort_valid", 32'(o_valid[0]), 0);
    chk("abort_state", 32'(o_state[0]), 32'hA5);

    // Priority: seed_load wins over out_enable and enable.
    cyc(1'b1, 8'h3C, 1'b1, 1'b1);
    chk("prio_state", 32'(o_state[0]), 32'h3C);
    chk("prio_no_valid", 32'(o_valid[0]), 0);

    // Retrigger with out_enable held: 8 bits, one gap, 8 bits, state frozen.
    saved = o_state[0];
    nvalid = 0;
    for (int k = 0; k < 17; k++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b1);
      nvalid += int'(o_valid[0]);
      if (k == 8) chk("retrig_gap", 32'(o_valid[0]), 0);
    end
    chk("retrig_nvalid", nvalid, 16);
    chk("retrig_frozen", 32'(o_state[0]), 32'(saved));

    // Asynchronous reset in the middle of a readout.
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(o_valid[0]), 0);
    chk("rst_busy", 32'(o_busy[0]), 0);
    chk("rst_out", 32'(o_out[0]), 0);
    chk("rst_state", 32'(o_state[0]), 32'h01);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_all();

    // Randomised traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      cyc($urandom_range(0, 15) == 0,
          ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
          1'($urandom_range(0, 1)),
          $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
